// File: rtl/audio_capture_pkg.sv
// Shared types and constants for the audio record path: FSM states,
// channel-select encoding and the two-samples-per-word layout.
package audio_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY0,
    S_ACK0,
    S_WAIT_RDY1,
    S_ACK1,
    S_WRITE,
    S_NEXT
  } state_e;

  localparam logic [1:0] CH_LEFT  = 2'b00;
  localparam logic [1:0] CH_RIGHT = 2'b01;
  localparam logic [1:0] CH_AVG   = 2'b10;

  // Earlier sample lives in the low half so playback can unpack in order.
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned LO_LSB   = 0;
  localparam int unsigned HI_LSB   = 16;

endpackage

// File: rtl/audio_sample_mix.sv
// Combinational stereo-to-mono reducer: left, right, or floor average.
module audio_sample_mix
  import audio_capture_pkg::*;
(
  input  logic [1:0]          chan_sel_i,
  input  logic [SAMPLE_W-1:0] left_i,
  input  logic [SAMPLE_W-1:0] right_i,
  output logic [SAMPLE_W-1:0] mono_o
);

  logic signed [SAMPLE_W:0] sum;

  // 17-bit sum never overflows; arithmetic shift floors toward minus infinity.
  always_comb begin
    sum = $signed({left_i[SAMPLE_W-1], left_i}) + $signed({right_i[SAMPLE_W-1], right_i});
    case (chan_sel_i)
      CH_LEFT:  mono_o = left_i;
      CH_RIGHT: mono_o = right_i;
      CH_AVG:   mono_o = SAMPLE_W'(sum >>> 1);
      default:  mono_o = left_i;
    endcase
  end

endmodule

// File: rtl/audio_capture_writer.sv
// Record path: pops codec sample pairs, mixes to mono, packs two samples per
// 32-bit word and writes them sequentially over an Avalon-MM write master.
module audio_capture_writer
  import audio_capture_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter logic [23:0] WORD_COUNT = 24'h100000,
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [1:0]        chan_sel,
  input  logic              read_ready,
  input  logic [15:0]       readdata_left,
  input  logic [15:0]       readdata_right,
  output logic              read_s,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [23:0]       words_written
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 24'd1);

  state_e            state_q, state_d;
  logic              read_s_q, read_s_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [23:0]       words_q, words_d;
  logic [31:0]       wait_cnt_q, wait_cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              stop_req;
  logic              last_word;
  logic [15:0]       mono;

  audio_sample_mix u_mix (
    .chan_sel_i (chan_sel),
    .left_i     (readdata_left),
    .right_i    (readdata_right),
    .mono_o     (mono)
  );

  assign stop_req  = stop || stop_pend_q;
  assign last_word = (addr_q == LAST_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start && !stop) state_d = S_WAIT_RDY0;
      S_WAIT_RDY0: if (stop_req) state_d = S_IDLE; else if (read_ready) state_d = S_ACK0;
      S_ACK0:      if (!read_ready) state_d = S_WAIT_RDY1;
      S_WAIT_RDY1: if (stop_req) state_d = S_IDLE; else if (read_ready) state_d = S_ACK1;
      S_ACK1:      if (!read_ready) state_d = S_WRITE;
      S_WRITE:     if (!mem_waitrequest) state_d = S_NEXT;
      S_NEXT:      state_d = (stop_req || (last_word && !loop)) ? S_IDLE : S_WAIT_RDY0;
      default:     state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they align with it.
  always_comb begin
    read_s_d    = (state_d == S_ACK0) || (state_d == S_ACK1);
    mem_write_d = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
    stop_pend_d = (state_d == S_IDLE) ? 1'b0 : stop_req;
    addr_d      = addr_q;
    data_d      = data_q;
    err_d       = err_q;
    words_d     = words_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (state_q)
      S_IDLE: if (state_d == S_WAIT_RDY0) begin
        addr_d  = '0;
        words_d = '0;
        err_d   = 1'b0;
      end
      S_WAIT_RDY0: if (state_d == S_ACK0) data_d[LO_LSB +: SAMPLE_W] = mono;
      S_WAIT_RDY1: if (state_d == S_ACK1) data_d[HI_LSB +: SAMPLE_W] = mono;
      S_ACK1:      wait_cnt_d = '0;
      S_WRITE: begin
        if (mem_waitrequest) begin
          if (WAIT_LIMIT != 0) begin
            if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 32'd1;
            if ((wait_cnt_q + 32'd1) >= WAIT_LIMIT) err_d = 1'b1;
          end
        end else begin
          words_d = words_q + 24'd1;
        end
      end
      S_NEXT: if (state_d == S_WAIT_RDY0) begin
        if (last_word) begin
          addr_d  = '0;
          words_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_s_q    <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      wait_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      read_s_q    <= read_s_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      words_q     <= words_d;
      wait_cnt_q  <= wait_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign read_s         = read_s_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = addr_q;
  assign mem_writedata  = data_q;
  assign mem_byteenable = 4'hF;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_written  = words_q;

  a_write_stable: assert property (@(posedge clk) disable iff (reset)
    (mem_write_q && mem_waitrequest) |=> ($stable(addr_q) && $stable(data_q)));

endmodule

// File: tb/tb_audio_capture_writer.sv
// Randomized scoreboard bench for audio_capture_writer with a behavioural
// codec/memory model and a decoupled write monitor.
module tb_audio_capture_writer;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned WC     = 4;
  localparam int unsigned WLIM   = 5;

  logic              clk = 1'b0;
  logic              reset, start, stop, loop;
  logic [1:0]        chan_sel;
  logic              read_ready;
  logic [15:0]       readdata_left, readdata_right;
  logic              read_s, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_waitrequest;
  logic              busy, done, err;
  logic [23:0]       words_written;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         m_exp;
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned stall_len = 0;
  int unsigned m_wcnt;
  int          done_count  = 0;
  int          write_count = 0;
  int unsigned exp_addr;
  int          half;
  logic [15:0] lo_sample;
  logic        m_active = 1'b0;
  logic        m_chk_inc = 1'b0;
  int unsigned m_len;
  logic [ADDR_W-1:0] m_a0;
  logic [31:0] m_d0;
  logic [23:0] m_ww0;

  audio_capture_writer #(
    .ADDR_W     (ADDR_W),
    .WORD_COUNT (24'(WC)),
    .WAIT_LIMIT (WLIM)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .loop            (loop),
    .chan_sel        (chan_sel),
    .read_ready      (read_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read_s          (read_s),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_byteenable  (mem_byteenable),
    .mem_waitrequest (mem_waitrequest),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .words_written   (words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Mono sample from the mixing rules: average is floor((L+R)/2).
  function automatic logic [15:0] ref_mono(input logic [1:0] sel, input logic [15:0] l,
                                           input logic [15:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    case (sel)
      2'b01:   return r;
      2'b10:   return 16'((s < 0 && (s % 2) != 0) ? (s / 2 - 1) : (s / 2));
      default: return l;
    endcase
  endfunction

  task automatic model_accept(input logic [15:0] m);
    wr_t w;
    if (half == 0) begin
      lo_sample = m;
      half = 1;
    end else begin
      w.addr = ADDR_W'(exp_addr);
      w.data = {m, lo_sample};
      exp_q.push_back(w);
      exp_addr = (exp_addr + 1) % WC;
      half = 0;
    end
  endtask

  task automatic send_sample(input logic [15:0] l, input logic [15:0] r);
    bit ok;
    @(posedge clk); #1;
    readdata_left  = l;
    readdata_right = r;
    read_ready     = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (read_s) begin ok = 1; break; end
    end
    check("read_s_rise_timeout", 64'(ok), 64'd1);
    if (ok) model_accept(ref_mono(chan_sel, l, r));
    @(posedge clk); #1;
    read_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!read_s) begin ok = 1; break; end
    end
    check("read_s_fall_timeout", 64'(ok), 64'd1);
  endtask

  task automatic pulse(input bit s, input bit p);
    @(posedge clk); #1;
    start = s;
    stop  = p;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic start_pass();
    exp_addr = 0;
    half     = 0;
    pulse(1'b1, 1'b0);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    check("done_timeout", 64'(ok), 64'd1);
  endtask

  // Memory model: stalls each write for stall_len cycles.
  initial begin
    mem_waitrequest = 1'b0;
    m_wcnt = 0;
    forever begin
      @(posedge clk); #2;
      if (mem_write && m_wcnt < stall_len) begin
        mem_waitrequest = 1'b1;
        m_wcnt++;
      end else begin
        mem_waitrequest = 1'b0;
        if (!mem_write) m_wcnt = 0;
      end
    end
  end

  // Write monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_active  = 1'b0;
        m_chk_inc = 1'b0;
      end else begin
        if (m_chk_inc) begin
          check("words_inc", 64'(words_written), 64'(m_ww0) + 64'd1);
          m_chk_inc = 1'b0;
        end
        if (done) done_count++;
        if (mem_write) begin
          if (!m_active) begin
            m_active = 1'b1;
            m_len    = 0;
            m_a0     = mem_address;
            m_d0     = mem_writedata;
            m_ww0    = words_written;
          end else begin
            check("stall_addr", 64'(mem_address), 64'(m_a0));
            check("stall_data", 64'(mem_writedata), 64'(m_d0));
          end
          m_len++;
          if (!mem_waitrequest) begin
            m_active = 1'b0;
            write_count++;
            check("words_hold", 64'(words_written), 64'(m_ww0));
            check("wr_len", 64'(m_len), 64'(stall_len + 1));
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_write: addr %0h data %0h with none expected",
                       mem_address, mem_writedata);
            end else begin
              m_exp = exp_q.pop_front();
              check("wr_addr", 64'(mem_address), 64'(m_exp.addr));
              check("wr_data", 64'(mem_writedata), 64'(m_exp.data));
            end
            m_chk_inc = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] avg_l[3];
    logic [15:0] avg_r[3];
    logic [15:0] l, r;
    int d0, w0;
    bit ok;
    avg_l = '{16'h7FFF, 16'h8000, 16'hFFFF};
    avg_r = '{16'h7FFF, 16'h0000, 16'h0000};

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; chan_sel = 2'b00;
    read_ready = 1'b0; readdata_left = '0; readdata_right = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_read_s", 64'(read_s), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_data", 64'(mem_writedata), 64'd0);
    check("byteenable", 64'(mem_byteenable), 64'hF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done_count), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);

    // One full pass per channel-select code.
    for (int p = 0; p < 4; p++) begin
      chan_sel  = 2'(p);
      stall_len = (p == 0) ? 0 : (p == 1) ? 3 : $urandom_range(0, 3);
      d0 = done_count;
      w0 = write_count;
      start_pass();
      for (int i = 0; i < 2 * WC; i++) begin
        l = 16'($urandom);
        r = 16'($urandom);
        if (p == 0 && i == 0) l = 16'h1234;
        if (p == 0 && i == 1) l = 16'h8001;
        if (p == 2 && i < 3) begin l = avg_l[i]; r = avg_r[i]; end
        send_sample(l, r);
        if (p == 1 && i == 2) pulse(1'b1, 1'b0);
      end
      wait_done();
      @(negedge clk);
      check("pass_busy", 64'(busy), 64'd0);
      check("pass_words", 64'(words_written), 64'(WC));
      check("pass_done_pulses", 64'(done_count - d0), 64'd1);
      check("pass_writes", 64'(write_count - w0), 64'(WC));
      check("pass_queue_empty", 64'(exp_q.size()), 64'd0);
      check("pass_err", 64'(err), 64'd0);
    end

    // start and stop together in IDLE: nothing happens.
    d0 = done_count;
    pulse(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("ss_busy", 64'(busy), 64'd0);
    check("ss_done", 64'(done_count - d0), 64'd0);
    check("ss_read_s", 64'(read_s), 64'd0);

    // Looping capture, then stop with a half-packed word.
    loop      = 1'b1;
    chan_sel  = 2'($urandom_range(0, 3));
    stall_len = 0;
    d0 = done_count;
    w0 = write_count;
    start_pass();
    for (int i = 0; i < 13; i++) send_sample(16'($urandom), 16'($urandom));
    check("loop_writes", 64'(write_count - w0), 64'd6);
    check("loop_no_done", 64'(done_count - d0), 64'd0);
    check("loop_busy", 64'(busy), 64'd1);
    pulse(1'b0, 1'b1);
    wait_done();
    repeat (4) @(negedge clk);
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_done", 64'(done_count - d0), 64'd1);
    check("stop_words", 64'(words_written), 64'd2);
    check("stop_no_half_write", 64'(write_count - w0), 64'd6);
    loop = 1'b0;

    // Long stall raises err; reset in the middle of the next write.
    chan_sel  = 2'b00;
    stall_len = 8;
    start_pass();
    send_sample(16'($urandom), 16'($urandom));
    send_sample(16'($urandom), 16'($urandom));
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (words_written == 24'd1) begin ok = 1; break; end
    end
    check("err_write_done", 64'(ok), 64'd1);
    check("err_set", 64'(err), 64'd1);
    @(posedge clk);
    stall_len = 50;
    send_sample(16'($urandom), 16'($urandom));
    send_sample(16'($urandom), 16'($urandom));
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_write) begin ok = 1; break; end
    end
    check("rst_write_seen", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_mem_write", 64'(mem_write), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_err", 64'(err), 64'd0);
    check("async_addr", 64'(mem_address), 64'd0);
    check("async_words", 64'(words_written), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    stall_len = 0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_write", 64'(mem_write), 64'd0);
    check("post_rst_read_s", 64'(read_s), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
